// File: rtl/acq_engine.sv
// acq_engine: trigger-armed capture of synchronised probe samples
// into the sample RAM write port, granted by the task dispatcher.
module acq_engine #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 9,
  parameter int DIV_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  grant_acq,
  output logic                  done_acq,
  input  logic [DATA_W-1:0]     probe,
  input  logic [DATA_W-1:0]     trig_mask,
  input  logic [DATA_W-1:0]     trig_value,
  input  logic [DIV_W-1:0]      div,
  output logic                  wr_en,
  output logic [DEPTH_LOG2-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  triggered
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_CAPTURE,
    S_DONE,
    S_WAIT_REL
  } state_t;

  localparam logic [DEPTH_LOG2-1:0] ADDR_ONE = DEPTH_LOG2'(1);
  localparam logic [DIV_W-1:0]      CNT_ONE  = DIV_W'(1);

  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       probe_s1_q, probe_s2_q;
  logic [DIV_W-1:0]        cnt_q, cnt_d;
  logic [DIV_W-1:0]        div_l_q, div_l_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic                    wr_en_q, wr_en_d;
  logic [DEPTH_LOG2-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]       wr_data_q, wr_data_d;
  logic                    trig_q, trig_d;
  logic                    done_q, done_d;

  logic tick;
  logic hit;
  logic last;

  assign tick = (cnt_q == div_l_q);
  assign hit  = ((probe_s2_q ^ trig_value) & trig_mask) == '0;
  assign last = (idx_q == '1);

  // Two-flop synchroniser for the asynchronous probe inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      probe_s1_q <= '0;
      probe_s2_q <= '0;
    end else begin
      probe_s1_q <= probe;
      probe_s2_q <= probe_s1_q;
    end
  end

  // Next-state, divider, sample index and registered write port
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    div_l_d   = div_l_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    trig_d    = trig_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_acq) begin
          state_d = S_ARM;
          div_l_d = div;
          trig_d  = 1'b0;
          idx_d   = '0;
        end
      end
      S_ARM: begin
        if (!grant_acq) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (hit) begin
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = probe_s2_q;
            trig_d    = 1'b1;
            idx_d     = ADDR_ONE;
            state_d   = S_CAPTURE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_CAPTURE: begin
        if (!grant_acq) begin
          state_d = S_IDLE;
        end else if (tick) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = probe_s2_q;
          idx_d     = idx_q + ADDR_ONE;
          if (last) begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        // done is registered so it lands one cycle after the last wr_en
        done_d  = 1'b1;
        state_d = S_WAIT_REL;
      end
      S_WAIT_REL: begin
        if (!grant_acq) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_l_q   <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      trig_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_l_q   <= div_l_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      trig_q    <= trig_d;
      done_q    <= done_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign triggered = trig_q;
  assign done_acq  = done_q;

endmodule

// File: tb/tb_acq_engine.sv
// tb_acq_engine: directed table-driven bench for acq_engine
// with a 16-sample capture depth.
module tb_acq_engine;

  localparam int DW = 8;
  localparam int DL = 4;
  localparam int VW = 16;
  localparam int NS = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          grant;
  logic          done_acq;
  logic [DW-1:0] probe;
  logic [DW-1:0] mask;
  logic [DW-1:0] value;
  logic [VW-1:0] div;
  logic          wr_en;
  logic [DL-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          triggered;

  acq_engine #(
    .DATA_W    (DW),
    .DEPTH_LOG2(DL),
    .DIV_W     (VW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .grant_acq (grant),
    .done_acq  (done_acq),
    .probe     (probe),
    .trig_mask (mask),
    .trig_value(value),
    .div       (div),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .triggered (triggered)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [DW-1:0] mask;
    logic [DW-1:0] value;
    logic [DW-1:0] probe;
    bit            ramp;
    logic [VW-1:0] div;
    logic [DW-1:0] d0;
    int            step;
    int            gap;
  } vec_t;

  vec_t vecs[5];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_run(input vec_t v, input bit hold, output int nw);
    int last;
    int bad;
    bit fin;
    logic [DW-1:0] ed;
    mask  = v.mask;
    value = v.value;
    div   = v.div;
    probe = v.ramp ? '0 : v.probe;
    repeat (3) @(negedge clk);
    grant = 1'b1;
    nw    = 0;
    last  = 0;
    fin   = 1'b0;
    for (int c = 0; c < 600 && !fin; c++) begin
      @(negedge clk);
      if (wr_en) begin
        ed = v.d0 + DW'(nw * v.step);
        check({v.name, " addr"}, int'(wr_addr), nw);
        check({v.name, " data"}, int'(wr_data), int'(ed));
        if (nw == 0) check({v.name, " trig"}, int'(triggered), 1);
        else check({v.name, " gap"}, c - last, v.gap);
        check({v.name, " wr_with_done"}, int'(done_acq), 0);
        nw++;
        last = c;
      end
      if (done_acq) begin
        check({v.name, " count"}, nw, NS);
        check({v.name, " done_lag"}, c - last, 1);
        fin = 1'b1;
      end
      if (v.ramp) probe = probe + 1'b1;
    end
    if (!fin) begin
      check({v.name, " timeout"}, 0, 1);
    end else begin
      @(negedge clk);
      check({v.name, " done_width"}, int'(done_acq), 0);
    end
    if (hold) begin
      bad = 0;
      repeat (20) begin
        @(negedge clk);
        if (wr_en || done_acq) bad++;
      end
      check({v.name, " hold_quiet"}, bad, 0);
    end
    grant = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int nw;
    int extra;
    int dn;

    vecs[0] = '{"mask0_div0", 8'h00, 8'h00, 8'h5A, 1'b0, 16'd0, 8'h5A, 0, 1};
    vecs[1] = '{"ramp_F0_A0", 8'hF0, 8'hA0, 8'h00, 1'b1, 16'd0, 8'hA0, 1, 1};
    vecs[2] = '{"div3", 8'h00, 8'h00, 8'h3C, 1'b0, 16'd3, 8'h3C, 0, 4};
    vecs[3] = '{"full_match_div1", 8'hFF, 8'h77, 8'h77, 1'b0, 16'd1, 8'h77, 0, 2};
    vecs[4] = '{"ramp_0F_05", 8'h0F, 8'h05, 8'h00, 1'b1, 16'd0, 8'h05, 1, 1};

    rst   = 1'b1;
    grant = 1'b0;
    probe = '0;
    mask  = '0;
    value = '0;
    div   = '0;
    repeat (3) @(negedge clk);
    check("rst wr_en", int'(wr_en), 0);
    check("rst wr_addr", int'(wr_addr), 0);
    check("rst wr_data", int'(wr_data), 0);
    check("rst done", int'(done_acq), 0);
    check("rst trig", int'(triggered), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) do_run(vecs[i], 1'b0, nw);

    // abort while armed: pattern never matches
    mask  = 8'hFF;
    value = 8'h11;
    probe = 8'h22;
    div   = '0;
    repeat (3) @(negedge clk);
    grant = 1'b1;
    extra = 0;
    dn    = 0;
    repeat (10) begin
      @(negedge clk);
      if (wr_en) extra++;
    end
    grant = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (wr_en) extra++;
      if (done_acq) dn++;
    end
    check("arm_abort writes", extra, 0);
    check("arm_abort done", dn, 0);
    do_run(vecs[0], 1'b0, nw);

    // abort during capture after 5 writes
    mask  = '0;
    probe = 8'h44;
    repeat (3) @(negedge clk);
    grant = 1'b1;
    nw    = 0;
    for (int c = 0; c < 100 && grant; c++) begin
      @(negedge clk);
      if (wr_en) nw++;
      if (nw == 5) grant = 1'b0;
    end
    extra = 0;
    dn    = 0;
    repeat (10) begin
      @(negedge clk);
      if (wr_en) extra++;
      if (done_acq) dn++;
    end
    grant = 1'b0;
    check("cap_abort writes", nw, 5);
    check("cap_abort extra", extra, 0);
    check("cap_abort done", dn, 0);
    check("cap_abort trig_held", int'(triggered), 1);
    do_run(vecs[2], 1'b0, nw);

    // grant held after done, then a fresh run from addr 0
    do_run(vecs[0], 1'b1, nw);
    do_run(vecs[3], 1'b0, nw);

    // reset pulsed mid-capture
    mask  = '0;
    probe = 8'h66;
    div   = '0;
    repeat (3) @(negedge clk);
    grant = 1'b1;
    nw    = 0;
    for (int c = 0; c < 100 && nw < 3; c++) begin
      @(negedge clk);
      if (wr_en) nw++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    grant = 1'b0;
    check("mid_rst wr_en", int'(wr_en), 0);
    check("mid_rst wr_addr", int'(wr_addr), 0);
    check("mid_rst wr_data", int'(wr_data), 0);
    check("mid_rst done", int'(done_acq), 0);
    check("mid_rst trig", int'(triggered), 0);
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (wr_en || done_acq) extra++;
    end
    check("mid_rst quiet", extra, 0);
    do_run(vecs[1], 1'b0, nw);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
